// File: rtl/clock_enable_scheduler_pkg.sv
// Shared types and helpers for clock_enable_scheduler.
// Contents:
//   state_e   - scheduler FSM states (idle / run / wait)
//   id_width  - requester-id width for a given requester count (minimum 1)
//   ID_W      - id width for the default of four requesters
//   len_slice - extracts one requester's burst-length field from the packed length bus
package clock_enable_scheduler_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWait
    } state_e;

    localparam int unsigned MAX_N_REQ   = 16;
    localparam int unsigned MAX_LEN_W   = 16;
    localparam int unsigned MAX_LEN_BUS = MAX_N_REQ * MAX_LEN_W;
    localparam int unsigned N_REQ_DEF   = 4;

    // A single requester still needs a 1-bit id, so clamp the width at 1.
    function automatic int unsigned id_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned ID_W = id_width(N_REQ_DEF);

    // Bits [idx*len_w +: len_w] of the zero-padded length bus, right-aligned.
    function automatic logic [MAX_LEN_W-1:0] len_slice(
        input logic [MAX_LEN_BUS-1:0] bus,
        input int unsigned            idx,
        input int unsigned            len_w
    );
        logic [MAX_LEN_BUS-1:0] shifted;
        logic [MAX_LEN_W-1:0]   mask;
        shifted = bus >> (idx * len_w);
        mask    = MAX_LEN_W'((32'd1 << len_w) - 32'd1);
        return shifted[MAX_LEN_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/clock_enable_scheduler_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req    in  N_REQ  request levels
//   ptr    in  ID_W   highest-priority position; the search starts here and wraps
//   valid  out 1      at least one request is set
//   id     out ID_W   index of the winner
//   onehot out N_REQ  winner as a one-hot vector (all zero when no request is set)
module rr_pick
    import clock_enable_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]             req,
    input  logic [id_width(N_REQ)-1:0]   ptr,
    output logic                         valid,
    output logic [id_width(N_REQ)-1:0]   id,
    output logic [N_REQ-1:0]             onehot
);

    localparam int unsigned IdW = id_width(N_REQ);

    logic [IdW-1:0] idx;

    always_comb begin
        valid  = 1'b0;
        id     = '0;
        onehot = '0;
        idx    = '0;
        // Walk from ptr upwards; the first hit (smallest wrapped offset) wins.
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = IdW'((32'(ptr) + i) % N_REQ);
            if (req[idx] && !valid) begin
                valid = 1'b1;
                id    = idx;
            end
        end
        if (valid) begin
            onehot[id] = 1'b1;
        end
    end

endmodule

// File: rtl/clock_enable_scheduler.sv
// Grants bursts of clock-enabled cycles on one shared sub-component to N_REQ requesters,
// round-robin, with a forced idle gap after every burst.
// Ports:
//   clk          in  1            clock
//   reset        in  1            synchronous active-high reset
//   io_req       in  N_REQ        request levels, held until done or abort
//   io_len       in  N_REQ*LEN_W  burst length per requester (len+1 enabled cycles)
//   io_grant     out N_REQ        one-hot owner while running
//   io_done      out N_REQ        one-hot pulse on the last cycle of a completed burst
//   io_abort     out N_REQ        one-hot pulse when the owner drops its request
//   io_result    out 1            io_sub_valid on the last burst cycle, else 0
//   io_sub_en    out 1            clock enable to the sub-component
//   io_sub_ready out 1            data-ready to the sub-component (same as io_sub_en)
//   io_sub_valid in  1            status from the sub-component
module clock_enable_scheduler
    import clock_enable_scheduler_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         io_req,
    input  logic [N_REQ*LEN_W-1:0]   io_len,
    output logic [N_REQ-1:0]         io_grant,
    output logic [N_REQ-1:0]         io_done,
    output logic [N_REQ-1:0]         io_abort,
    output logic                     io_result,
    output logic                     io_sub_en,
    output logic                     io_sub_ready,
    input  logic                     io_sub_valid
);

    localparam int unsigned IdW = id_width(N_REQ);
    localparam logic [2:0]  GapLoad = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    state_e                 state_q, state_d;
    logic [IdW-1:0]         id_q, id_d;
    logic [N_REQ-1:0]       own_q, own_d;
    logic [LEN_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             gap_q, gap_d;
    logic [IdW-1:0]         rr_ptr_q, rr_ptr_d;

    logic                   pick_valid;
    logic [IdW-1:0]         pick_id;
    logic [N_REQ-1:0]       pick_onehot;
    logic [MAX_LEN_BUS-1:0] len_bus;
    logic                   in_run, owner_req, fire, last, drop;
    logic [IdW-1:0]         next_ptr;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req    (io_req),
        .ptr    (rr_ptr_q),
        .valid  (pick_valid),
        .id     (pick_id),
        .onehot (pick_onehot)
    );

    // Outputs decode registered state; only the abort gating looks at the live request.
    always_comb begin
        in_run    = (state_q == StRun);
        owner_req = |(io_req & own_q);
        fire      = in_run && owner_req;
        drop      = in_run && !owner_req;
        last      = fire && (cnt_q == '0);

        io_grant     = fire ? own_q : '0;
        io_sub_en    = fire;
        io_sub_ready = fire;
        io_done      = last ? own_q : '0;
        io_abort     = drop ? own_q : '0;
        io_result    = last & io_sub_valid;
    end

    always_comb begin
        len_bus                    = '0;
        len_bus[N_REQ*LEN_W-1:0]   = io_len;
        next_ptr = (id_q == IdW'(N_REQ - 1)) ? '0 : id_q + 1'b1;

        state_d  = state_q;
        id_d     = id_q;
        own_d    = own_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        rr_ptr_d = rr_ptr_q;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StRun;
                    id_d    = pick_id;
                    own_d   = pick_onehot;
                    cnt_d   = LEN_W'(len_slice(len_bus, 32'(pick_id), LEN_W));
                end
            end
            StRun: begin
                if (drop || last) begin
                    state_d  = (GAP > 0) ? StWait : StIdle;
                    gap_d    = GapLoad;
                    rr_ptr_d = next_ptr;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StWait: begin
                if (gap_q == '0) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            id_q     <= '0;
            own_q    <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            id_q     <= id_d;
            own_q    <= own_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Self-checking bench for clock_enable_scheduler (N_REQ=4, LEN_W=4; GAP=1 and GAP=0 copies).
module tb_clock_enable_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] len = '0;
    logic        sub_valid = 1'b0;
    logic [3:0]  grant, done, abort;
    logic        result, sub_en, sub_ready;

    logic [3:0]  req_z = '0;
    logic [15:0] len_z = '0;
    logic [3:0]  grant_z, done_z, abort_z;
    logic        result_z, en_z, ready_z;

    always #5 clk = ~clk;

    clock_enable_scheduler #(.N_REQ(4), .LEN_W(4), .GAP(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .io_req       (req),
        .io_len       (len),
        .io_grant     (grant),
        .io_done      (done),
        .io_abort     (abort),
        .io_result    (result),
        .io_sub_en    (sub_en),
        .io_sub_ready (sub_ready),
        .io_sub_valid (sub_valid)
    );

    clock_enable_scheduler #(.N_REQ(4), .LEN_W(4), .GAP(0)) dut_gap0 (
        .clk          (clk),
        .reset        (reset),
        .io_req       (req_z),
        .io_len       (len_z),
        .io_grant     (grant_z),
        .io_done      (done_z),
        .io_abort     (abort_z),
        .io_result    (result_z),
        .io_sub_en    (en_z),
        .io_sub_ready (ready_z),
        .io_sub_valid (1'b0)
    );

    typedef struct {
        logic       is_abort;
        logic [3:0] onehot;
        logic       result;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_checks = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    int   t, e0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input logic is_abort, input logic [3:0] oh, input logic res, input int c);
        exp_t e;
        e.is_abort = is_abort;
        e.onehot   = oh;
        e.result   = res;
        e.cyc      = c;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: per-cycle invariants plus scoreboard matching of done/abort pulses.
    always @(negedge clk) begin
        if (sub_en) en_cnt++;
        check_eq("ready_eq_en", 32'(sub_ready), 32'(sub_en));
        check_eq("en_eq_grant", 32'(sub_en), 32'(|grant));
        check_eq("done_abort_excl", 32'((|done) && (|abort)), 0);
        if (done == 4'b0000) check_eq("result_quiet", 32'(result), 0);
        if ((done | abort) != 4'b0000) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_event", 32'({abort, done}), 0);
            end else begin
                cur = sb.pop_front();
                check_eq("ev_kind", 32'(|abort), 32'(cur.is_abort));
                check_eq("ev_onehot", 32'(done | abort), 32'(cur.onehot));
                check_eq("ev_result", 32'(result), 32'(cur.result));
                check_eq("ev_cycle", cyc, cur.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_grant", 32'(grant), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_abort", 32'(abort), 0);
        check_eq("rst_result", 32'(result), 0);
        check_eq("rst_sub_en", 32'(sub_en), 0);
        check_eq("rst_sub_ready", 32'(sub_ready), 0);
        reset = 1'b0;

        // Round-robin, all requesters, len=0: 0,1,2,3,0 every 3 cycles
        tick(1);
        t = cyc;
        req = 4'b1111;
        len = 16'h0000;
        for (int k = 0; k < 5; k++) push(1'b0, 4'b0001 << (k % 4), 1'b0, t + 1 + 3 * k);
        tick(14);
        req = 4'b0000;
        tick(2);

        // Single requester 1, len=3: 4 enabled cycles, done on the 4th
        t = cyc;
        e0 = en_cnt;
        req = 4'b0010;
        len = 16'h0030;
        push(1'b0, 4'b0010, 1'b0, t + 4);
        tick(1);
        check_eq("single_grant", 32'(grant), 32'(4'b0010));
        tick(4);
        check_eq("single_wait_en", 32'(sub_en), 0);
        req = 4'b0000;
        tick(1);
        check_eq("single_en_cycles", en_cnt - e0, 4);
        tick(1);

        // Abort: requester 2, len=5, drops in its 3rd run cycle; then ptr must sit at 3
        t = cyc;
        e0 = en_cnt;
        req = 4'b0100;
        len = 16'h0500;
        push(1'b1, 4'b0100, 1'b0, t + 3);
        tick(3);
        req = 4'b0000;
        #1;
        check_eq("abort_grant_gated", 32'(grant), 0);
        check_eq("abort_en_gated", 32'(sub_en), 0);
        tick(1);
        check_eq("abort_en_cycles", en_cnt - e0, 2);
        req = 4'b1001;
        len = 16'h0000;
        push(1'b0, 4'b1000, 1'b0, t + 6);
        push(1'b0, 4'b0001, 1'b0, t + 9);
        tick(6);
        req = 4'b0000;
        tick(2);

        // Result capture: len=2, sub_valid toggles, 1 on the last cycle
        t = cyc;
        req = 4'b0010;
        len = 16'h0020;
        push(1'b0, 4'b0010, 1'b1, t + 3);
        tick(1);
        sub_valid = 1'b1;
        tick(1);
        sub_valid = 1'b0;
        tick(1);
        sub_valid = 1'b1;
        tick(1);
        sub_valid = 1'b0;
        req = 4'b0000;
        tick(2);

        // Reset in run cycle 2 of a len=7 burst; afterwards requester 0 wins over 2
        t = cyc;
        e0 = en_cnt;
        req = 4'b0001;
        len = 16'h0007;
        tick(2);
        reset = 1'b1;
        tick(1);
        check_eq("mid_rst_grant", 32'(grant), 0);
        check_eq("mid_rst_en", 32'(sub_en), 0);
        check_eq("mid_rst_done", 32'(done), 0);
        tick(1);
        reset = 1'b0;
        check_eq("mid_rst_en_cycles", en_cnt - e0, 2);
        req = 4'b0101;
        len = 16'h0000;
        push(1'b0, 4'b0001, 1'b0, t + 5);
        push(1'b0, 4'b0100, 1'b0, t + 8);
        tick(5);
        req = 4'b0000;
        tick(2);

        // Maximum length: len=15 gives 16 enabled cycles
        t = cyc;
        e0 = en_cnt;
        req = 4'b1000;
        len = 16'hF000;
        push(1'b0, 4'b1000, 1'b0, t + 16);
        tick(17);
        req = 4'b0000;
        check_eq("len15_en_cycles", en_cnt - e0, 16);
        tick(2);

        // GAP=0: next grant after a single idle cycle
        req_z = 4'b0011;
        len_z = 16'h0000;
        tick(1);
        check_eq("gap0_grant0", 32'(grant_z), 32'(4'b0001));
        check_eq("gap0_done0", 32'(done_z), 32'(4'b0001));
        tick(1);
        check_eq("gap0_idle_grant", 32'(grant_z), 0);
        check_eq("gap0_idle_en", 32'(en_z), 0);
        tick(1);
        check_eq("gap0_grant1", 32'(grant_z), 32'(4'b0010));
        check_eq("gap0_done1", 32'(done_z), 32'(4'b0010));
        check_eq("gap0_abort", 32'(abort_z), 0);
        tick(1);
        req_z = 4'b0000;
        tick(3);

        check_eq("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_enable_scheduler.md
# clock_enable_scheduler

Shares one clock-enabled sub-component between `N_REQ` requesters. The sub-component runs only while this block asserts its enable, replacing a logic-derived clock. Each requester asks for a burst of enabled cycles; the block grants bursts round-robin, counts the burst length, enforces an idle gap between bursts, and returns a done pulse carrying the sub-component's final `valid` sample. It sits between requesting control logic and the gated sub-component, in the main `clk` domain.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters (2..16).
- `LEN_W`, default 4: burst-length field width; the burst is `len+1` enabled cycles.
- `GAP`, default 1: forced disabled cycles after each burst (0..7).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `io_req`  in  N_REQ  per-requester request level; must be held until `io_done` or abort.
- `io_len`  in  N_REQ*LEN_W  burst length per requester; slice i is bits [i*LEN_W +: LEN_W]; sampled at grant.
- `io_grant`  out  N_REQ  one-hot; the owner during RUN.
- `io_done`  out  N_REQ  one-hot 1-cycle pulse; burst completed.
- `io_abort`  out  N_REQ  one-hot 1-cycle pulse; burst cancelled by request drop.
- `io_result`  out  1  `io_sub_valid` sampled on the last RUN cycle; meaningful only with `io_done`.
- `io_sub_en`  out  1  clock enable to the sub-component.
- `io_sub_ready`  out  1  data-ready to the sub-component; equals `io_sub_en`.
- `io_sub_valid`  in  1  status from the sub-component.

## Operation
- States are IDLE, RUN and WAIT.
- In IDLE with any `io_req` bit set:
  - pick the first set bit at or above `rr_ptr`, wrapping;
  - latch the winner id and its `io_len` slice into `cnt`;
  - go to RUN.
- In RUN:
  - `io_grant[id]=1` and `io_sub_en=1`.
  - When `cnt==0`, this is the last cycle: pulse `io_done[id]` and drive `io_result=io_sub_valid`. Next state is WAIT if `GAP>0`, else IDLE.
  - Otherwise `cnt` decrements.
- Abort:
  - If `io_req[id]` is 0 in any RUN cycle, that cycle is not enabled: `io_sub_en=0` and `io_grant=0`.
  - `io_abort[id]` pulses in that cycle and the FSM goes to WAIT, or IDLE when `GAP=0`.
  - `io_done` is never asserted for an aborted burst.
- WAIT: `io_sub_en=0` for exactly `GAP` cycles via the gap counter, then IDLE.
- `rr_ptr` is set to `id+1` (mod `N_REQ`) on done or abort. It is unchanged otherwise.
- Other requesters changing `io_req`/`io_len` during RUN or WAIT have no effect until the next IDLE arbitration.
- `len=0` gives exactly one enabled cycle. `len=2^LEN_W-1` gives `2^LEN_W` cycles; no overflow, since `cnt` is `LEN_W` bits and only decrements.

## Timing
- Reset: state IDLE, `rr_ptr=0`, `cnt=0`. `io_grant`, `io_done`, `io_abort`, `io_result`, `io_sub_en` and `io_sub_ready` are all 0.
- Reset asserted mid-burst: `io_sub_en` is 0 from the next edge. No done or abort pulse is generated.
- Outputs are decoded from registered state (Moore), except the abort gating, which uses the current `io_req[id]`.
- Latency: request first seen in IDLE at cycle t gives:
  - grant and enable in cycles t+1 .. t+1+len;
  - `io_done` at t+1+len;
  - WAIT in t+2+len .. t+1+len+GAP;
  - next arbitration at t+2+len+GAP.
- Back-to-back requester throughput is one burst per `len+2+GAP` cycles.
- `io_done` and `io_abort` are never asserted together. At most one bit of each is set.

## Structure
- Package `clock_enable_scheduler_pkg` holds:
  - the state enum (IDLE/RUN/WAIT);
  - the derived constant `ID_W = clog2(N_REQ)`;
  - a function extracting the `io_len` slice.
- One sub-module, `rr_pick`: combinational round-robin picker. Inputs are `req` and `ptr`; outputs are `valid`, `id` and `onehot`.
- The FSM, counters and output registers live in the top module.

## Test plan
- Single requester: `io_req=4'b0010` with `len[1]=3` and `GAP=1`.
  - `io_grant=4'b0010` and `io_sub_en=1` for exactly 4 cycles.
  - `io_done=4'b0010` on the 4th cycle.
  - 1 disabled cycle, then IDLE.
- Round-robin with all four requesters held high and `len=0`.
  - Grant order 0,1,2,3,0.
  - Each burst is 1 enabled cycle, with bursts 3 cycles apart.
- Abort: requester 2 with `len=5` drops `io_req` in its 3rd RUN cycle.
  - Enable for exactly 2 cycles.
  - `io_abort=4'b0100` in the drop cycle; no `io_done`.
  - `rr_ptr=3` afterwards.
- Result capture: `io_sub_valid` toggles during a `len=2` burst and is 1 on its last cycle.
  - `io_result=1` coincident with `io_done`.
  - `io_result=0` in all other cycles.
- Reset mid-burst: `reset` asserted during RUN cycle 2 of a `len=7` burst.
  - All outputs 0 from the next edge; no done.
  - After release, requester 0 is granted first.
- Boundaries:
  - `len=15` gives exactly 16 enabled cycles.
  - With `GAP=0`, the next grant follows after a single IDLE cycle.
